sopc_onchip_ram_dp: RTL and testbench

//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1 = port A, s2 = port B).

---
 rtl/sopc_onchip_ram_dp_if.sv | 35 +++
 rtl/sopc_onchip_ram_dp.sv | 179 +++++++++++++++++
 tb/tb_sopc_onchip_ram_dp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sopc_onchip_ram_dp_if.sv
// sopc_onchip_ram_dp_if
//   One Avalon-MM slave port of the dual-port on-chip RAM.
//   master modport: the bus master side (drives requests, receives read data).
//   slave  modport: the RAM side (receives requests, returns read data).
// Signals
//   address        word address
//   chipselect     port select
//   read / write   request strobes (both high counts as a write)
//   byteenable     write byte lanes
//   writedata      write data
//   readdata       read data, holds its last value between reads
//   readdatavalid  one-cycle pulse per completed read
interface sopc_onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) ();
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sopc_onchip_ram_dp.sv
// sopc_onchip_ram_dp
//   True dual-port on-chip RAM with two Avalon-MM slaves (a = s1, b = s2).
//   Byte-lane writes, pipelined reads with readdatavalid, read-old-data on
//   read-during-write, port A priority on same-address same-lane writes,
//   and a sticky out-of-range flag.
// Ports
//   clk      system clock
//   reset    asynchronous active-high reset (outputs and read pipeline only)
//   clken    global clock enable; low freezes accepts, memory and pipeline
//   a, b     Avalon-MM slave ports (see sopc_onchip_ram_dp_if)
//   oor_clr  clears oor_err (a new out-of-range hit in the same cycle wins)
//   oor_err  sticky: some accepted access used an address >= DEPTH
module sopc_onchip_ram_dp #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 5000,
  parameter int    ADDR_W    = 13,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = "ram.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  sopc_onchip_ram_dp_if.slave a,
  sopc_onchip_ram_dp_if.slave b,
  input  logic                oor_clr,
  output logic                oor_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH as an ADDR_W+1 bit value so the range compare is width-exact
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("sopc_onchip_ram_dp: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("sopc_onchip_ram_dp: DATA_W must be a non-zero multiple of 8");
  end
  if (IDX_W > ADDR_W) begin : g_bad_addr_w
    $error("sopc_onchip_ram_dp: ADDR_W too small for DEPTH");
  end

  // ---------------------------------------------------------------------
  // Port gathering: index 0 = port A, index 1 = port B
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] p_addr  [2];
  logic [NB-1:0]     p_be    [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [1:0]        p_cs;
  logic [1:0]        p_rd;
  logic [1:0]        p_wr;

  always_comb begin
    p_addr[0]  = a.address;
    p_addr[1]  = b.address;
    p_be[0]    = a.byteenable;
    p_be[1]    = b.byteenable;
    p_wdata[0] = a.writedata;
    p_wdata[1] = b.writedata;
    p_cs       = {b.chipselect, a.chipselect};
    p_rd       = {b.read,       a.read};
    p_wr       = {b.write,      a.write};
  end

  // Accept decode. A simultaneous read+write strobe is treated as a write.
  logic [1:0]       in_range;
  logic [1:0]       rd_acc;
  logic [1:0]       wr_acc;
  logic [IDX_W-1:0] p_idx [2];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      in_range[i] = ({1'b0, p_addr[i]} < LIMIT);
      wr_acc[i]   = clken & p_cs[i] & p_wr[i];
      rd_acc[i]   = clken & p_cs[i] & p_rd[i] & ~p_wr[i];
      p_idx[i]    = p_addr[i][IDX_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Storage (never reset)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // Port B lanes are written first so that port A's writes to the same
  // word land last and win on lanes both ports enable.
  always_ff @(posedge clk) begin
    if (wr_acc[1] && in_range[1]) begin
      for (int unsigned l = 0; l < NB; l++) begin
        if (p_be[1][l]) mem[p_idx[1]][l*8 +: 8] <= p_wdata[1][l*8 +: 8];
      end
    end
    if (wr_acc[0] && in_range[0]) begin
      for (int unsigned l = 0; l < NB; l++) begin
        if (p_be[0][l]) mem[p_idx[0]][l*8 +: 8] <= p_wdata[0][l*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline stage 1: memory output register. Reading mem here sees
  // the pre-edge contents, giving old data on read-during-write.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] s1_data [2];
  logic [1:0]        s1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= '0;
      for (int unsigned i = 0; i < 2; i++) s1_data[i] <= '0;
    end else if (clken) begin
      s1_valid <= rd_acc;
      for (int unsigned i = 0; i < 2; i++) begin
        if (rd_acc[i]) s1_data[i] <= in_range[i] ? mem[p_idx[i]] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional stage 2 output register
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] q_data [2];
  logic [1:0]        q_valid;

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data [2];
    logic [1:0]        s2_valid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid <= '0;
        for (int unsigned i = 0; i < 2; i++) s2_data[i] <= '0;
      end else if (clken) begin
        s2_valid <= s1_valid;
        for (int unsigned i = 0; i < 2; i++) begin
          if (s1_valid[i]) s2_data[i] <= s1_data[i];
        end
      end
    end

    always_comb begin
      q_valid = s2_valid;
      for (int unsigned i = 0; i < 2; i++) q_data[i] = s2_data[i];
    end
  end else begin : g_lat1
    always_comb begin
      q_valid = s1_valid;
      for (int unsigned i = 0; i < 2; i++) q_data[i] = s1_data[i];
    end
  end

  assign a.readdata      = q_data[0];
  assign a.readdatavalid = q_valid[0];
  assign b.readdata      = q_data[1];
  assign b.readdatavalid = q_valid[1];

  // ---------------------------------------------------------------------
  // Sticky out-of-range flag; a new hit takes precedence over oor_clr
  // ---------------------------------------------------------------------
  logic oor_hit;

  always_comb begin
    oor_hit = |((rd_acc | wr_acc) & ~in_range);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oor_err <= 1'b0;
    end else if (clken) begin
      if (oor_hit)      oor_err <= 1'b1;
      else if (oor_clr) oor_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sopc_onchip_ram_dp.sv
module tb_sopc_onchip_ram_dp;
  localparam int DW    = 32;
  localparam int DEPTH = 5000;
  localparam int AW    = 13;
  localparam int LAT   = 2;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic clken   = 1'b1;
  logic oor_clr = 1'b0;
  logic oor_err;

  sopc_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
  sopc_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

  sopc_onchip_ram_dp #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .a(a_if), .b(b_if),
    .oor_clr(oor_clr), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: memory as a sparse map, reads as a queue of
  // (due enabled-edge number, data) per port.
  // ---------------------------------------------------------------------
  typedef struct { int unsigned due; logic [31:0] data; } rd_t;

  logic [31:0] mm [int];
  rd_t         qa [$];
  rd_t         qb [$];
  logic [31:0] m_da = '0, m_db = '0;
  logic        m_va = 1'b0, m_vb = 1'b0, m_oor = 1'b0;
  int unsigned ecnt = 0;

  function automatic logic [31:0] mread(input int ad);
    if (ad >= DEPTH) return 32'h0;
    if (mm.exists(ad)) return mm[ad];
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete(); qb.delete();
      m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0; m_oor = 1'b0;
    end else if (clken) begin
      logic wa, wb, hit;
      logic [31:0] w;
      int ad_a, ad_b;
      ad_a = int'(a_if.address);
      ad_b = int'(b_if.address);
      // reads capture memory as it was before this edge's writes
      if (a_if.chipselect && a_if.read && !a_if.write) qa.push_back('{ecnt + LAT, mread(ad_a)});
      if (b_if.chipselect && b_if.read && !b_if.write) qb.push_back('{ecnt + LAT, mread(ad_b)});
      wa = a_if.chipselect && a_if.write && (ad_a < DEPTH);
      wb = b_if.chipselect && b_if.write && (ad_b < DEPTH);
      if (wa) begin
        w = mread(ad_a);
        for (int l = 0; l < 4; l++) if (a_if.byteenable[l]) w[l*8 +: 8] = a_if.writedata[l*8 +: 8];
        mm[ad_a] = w;
      end
      if (wb) begin
        w = mread(ad_b);
        for (int l = 0; l < 4; l++)
          if (b_if.byteenable[l] && !(wa && ad_a == ad_b && a_if.byteenable[l]))
            w[l*8 +: 8] = b_if.writedata[l*8 +: 8];
        mm[ad_b] = w;
      end
      hit = (a_if.chipselect && (a_if.read || a_if.write) && ad_a >= DEPTH) ||
            (b_if.chipselect && (b_if.read || b_if.write) && ad_b >= DEPTH);
      if (hit) m_oor = 1'b1;
      else if (oor_clr) m_oor = 1'b0;
      ecnt++;
      m_va = 1'b0;
      if (qa.size() > 0 && qa[0].due == ecnt) begin m_va = 1'b1; m_da = qa[0].data; void'(qa.pop_front()); end
      m_vb = 1'b0;
      if (qb.size() > 0 && qb[0].due == ecnt) begin m_vb = 1'b1; m_db = qb[0].data; void'(qb.pop_front()); end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    chk("a_valid", {31'b0, a_if.readdatavalid}, {31'b0, m_va});
    chk("a_data",  a_if.readdata, m_da);
    chk("b_valid", {31'b0, b_if.readdatavalid}, {31'b0, m_vb});
    chk("b_data",  b_if.readdata, m_db);
    chk("oor_err", {31'b0, oor_err}, {31'b0, m_oor});
  end

  // Collect port A results that are consumed by an enabled edge
  logic        collect = 1'b0;
  logic [31:0] got [$];
  always @(negedge clk) begin
    if (collect && a_if.readdatavalid && clken) got.push_back(a_if.readdata);
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_if.chipselect = 1'b0; a_if.read = 1'b0; a_if.write = 1'b0;
    b_if.chipselect = 1'b0; b_if.read = 1'b0; b_if.write = 1'b0;
    oor_clr = 1'b0;
  endtask

  task automatic set_req(input bit p, input bit rd, input bit wr, input logic [AW-1:0] ad,
                         input logic [3:0] be, input logic [31:0] d);
    if (!p) begin
      a_if.chipselect = 1'b1; a_if.read = rd; a_if.write = wr;
      a_if.address = ad; a_if.byteenable = be; a_if.writedata = d;
    end else begin
      b_if.chipselect = 1'b1; b_if.read = rd; b_if.write = wr;
      b_if.address = ad; b_if.byteenable = be; b_if.writedata = d;
    end
  endtask

  task automatic wr(input bit p, input logic [AW-1:0] ad, input logic [3:0] be, input logic [31:0] d);
    set_req(p, 1'b0, 1'b1, ad, be, d); step(); idle();
  endtask

  // Waits (bounded) for the valid of an already-issued read on port p
  task automatic wait_chk(input bit p, input logic [31:0] exp, input string nm);
    int n;
    n = 1;
    while ((p ? b_if.readdatavalid : a_if.readdatavalid) !== 1'b1 && n < 10) begin
      step(); n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(LAT));
    chk({nm, "_data"}, p ? b_if.readdata : a_if.readdata, exp);
  endtask

  task automatic rd_chk(input bit p, input logic [AW-1:0] ad, input logic [31:0] exp, input string nm);
    set_req(p, 1'b1, 1'b0, ad, 4'h0, 32'h0); step(); idle();
    wait_chk(p, exp, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.address = '0; a_if.byteenable = '0; a_if.writedata = '0;
    b_if.address = '0; b_if.byteenable = '0; b_if.writedata = '0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", {31'b0, a_if.readdatavalid}, 32'h0);
    chk("rst_a_data",  a_if.readdata, 32'h0);
    chk("rst_b_data",  b_if.readdata, 32'h0);
    chk("rst_oor",     {31'b0, oor_err}, 32'h0);
    reset = 1'b0;
    step();

    // 1: full-word write and read-back latency
    wr(0, 13'd5, 4'hF, 32'hDEADBEEF);
    rd_chk(0, 13'd5, 32'hDEADBEEF, "t1");

    // 2: partial byte lanes over all-ones
    wr(0, 13'd7, 4'hF, 32'hFFFFFFFF);
    wr(0, 13'd7, 4'b0101, 32'h11223344);
    rd_chk(0, 13'd7, 32'hFF22FF44, "t2");

    // 3: same-address collision, A wins on shared lanes
    wr(0, 13'd9, 4'hF, 32'h00000000);
    set_req(0, 1'b0, 1'b1, 13'd9, 4'b0011, 32'hAAAAAAAA);
    set_req(1, 1'b0, 1'b1, 13'd9, 4'b0110, 32'h55555555);
    step(); idle();
    rd_chk(1, 13'd9, 32'h0055AAAA, "t3");

    // 4: cross-port read-during-write returns old data
    wr(1, 13'd3, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 13'd3, 4'h0, 32'h0);
    set_req(0, 1'b0, 1'b1, 13'd3, 4'hF, 32'h1);
    step(); idle();
    wait_chk(1, 32'h0, "t4_old");
    rd_chk(1, 13'd3, 32'h1, "t4_new");

    // read+write together counts as a write only: no read result expected
    set_req(0, 1'b1, 1'b1, 13'd11, 4'hF, 32'hCAFEF00D);
    step(); idle();
    repeat (3) step();
    rd_chk(0, 13'd11, 32'hCAFEF00D, "rw_both");

    // 5: out-of-range read, sticky flag, clear, set-beats-clear
    rd_chk(0, 13'd5000, 32'h0, "t5");
    chk("t5_oor_set", {31'b0, oor_err}, 32'h1);
    oor_clr = 1'b1; step(); idle();
    chk("t5_oor_clr", {31'b0, oor_err}, 32'h0);
    set_req(1, 1'b0, 1'b1, 13'd8191, 4'hF, 32'h12345678);
    oor_clr = 1'b1; step(); idle();
    chk("t5_set_wins", {31'b0, oor_err}, 32'h1);
    rd_chk(1, 13'd8191, 32'h0, "t5_b_oor");

    // 6: burst with clken low in the middle
    for (int i = 1; i <= 4; i++) wr(0, AW'(i), 4'hF, 32'h100 + 32'(i));
    got.delete();
    collect = 1'b1;
    set_req(0, 1'b1, 1'b0, 13'd1, 4'h0, 32'h0); step();
    set_req(0, 1'b1, 1'b0, 13'd2, 4'h0, 32'h0); step();
    clken = 1'b0;
    set_req(0, 1'b1, 1'b0, 13'd3, 4'h0, 32'h0); step();
    step();
    clken = 1'b1; step();
    set_req(0, 1'b1, 1'b0, 13'd4, 4'h0, 32'h0); step();
    idle();
    repeat (6) step();
    collect = 1'b0;
    chk("t6_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t6_order", (got.size() > i) ? got[i] : 32'hFFFFFFFF, 32'h101 + 32'(i));

    // 7: reset mid-burst drops in-flight reads and clears oor_err
    got.delete();
    collect = 1'b1;
    set_req(0, 1'b1, 1'b0, 13'd1, 4'h0, 32'h0); step();
    set_req(0, 1'b1, 1'b0, 13'd2, 4'h0, 32'h0); step();
    idle();
    #2 reset = 1'b1;
    step(); step();
    #2 reset = 1'b0;
    got.delete();
    repeat (6) step();
    collect = 1'b0;
    chk("t7_no_valid", 32'(got.size()), 32'd0);
    chk("t7_oor", {31'b0, oor_err}, 32'h0);
    rd_chk(0, 13'd2, 32'h102, "t7_mem_kept");

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
